hpu_job_seq: RTL and testbench

Job sequencer for the HPU stream datapath. It replaces the software-driven matw/run register toggling with a hardware state machine. A single start pulse from the AXI-Lite control register runs three phases: load the item memory (matw phase, counting accepted source beats), then a one-cycle arm gap, then the run phase until the output stream's last beat is accepted. Done and error status go back to the register file. It sits between the AXI-Lite register block and the core/src_ctrl/dst_ctrl datapath, in the AXIS_ACLK domain.

---
 rtl/hpu_pkg.sv | 20 ++
 rtl/hpu_wdt.sv | 44 ++++
 rtl/hpu_job_seq.sv | 158 +++++++++++++++
 tb/tb_hpu_job_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU job sequencer and its helpers.
//   hpu_state_e : job sequencer state encoding
//   ITEM_W_DEF  : default item counter width
//   TIMEOUT_DEF : default watchdog idle limit (0 disables)
//   JOB_CNT_W   : completed-job counter width
package hpu_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StArm  = 3'd2,
    StRun  = 3'd3,
    StDone = 3'd4
  } hpu_state_e;

  localparam int unsigned ITEM_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 1048576;
  localparam int unsigned JOB_CNT_W   = 32;

endpackage

// File: rtl/hpu_wdt.sv
// Saturating idle watchdog.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : phase is being watched; counter is held at 0 while low
//   clr        : a qualifying beat occurred this cycle; restarts the count
//   expired    : this cycle is the TIMEOUT-th consecutive idle cycle
// TIMEOUT = 0 disables the watchdog (expired never asserts).
module hpu_wdt #(
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] T_LIM = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || clr || (TIMEOUT == 0)) begin
      cnt_d = '0;
    end else if (cnt_q != T_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Flags the idle cycle that would bring the count to TIMEOUT, so the owner
  // leaves the phase on that same edge.
  assign expired = (TIMEOUT != 0) && en && !clr && (cnt_q >= T_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hpu_job_seq.sv
// HPU job sequencer: start pulse runs LOAD (item memory write) -> ARM (one
// idle cycle, datapath exe held in reset) -> RUN (until last output beat)
// -> DONE (one cycle), with abort and idle watchdog back to IDLE.
//   AXIS_ACLK, AXIS_ARESETN  : clock, asynchronous active-low reset
//   start, abort             : job start pulse, abort level
//   cfg_item_num, cfg_last   : job config, latched on an accepted start
//   src_beat, dst_last_beat  : accepted input beat, accepted last output beat
//   matw, run, last, mat_a   : datapath controls (all registered)
//   busy, done, done_flag, err_flag, job_cnt : status to the register file
module hpu_job_seq
  import hpu_pkg::*;
#(
  parameter int unsigned ITEM_W  = ITEM_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 AXIS_ACLK,
  input  logic                 AXIS_ARESETN,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ITEM_W-1:0]    cfg_item_num,
  input  logic                 cfg_last,
  input  logic                 src_beat,
  input  logic                 dst_last_beat,
  output logic                 matw,
  output logic                 run,
  output logic                 last,
  output logic [ITEM_W-1:0]    mat_a,
  output logic                 busy,
  output logic                 done,
  output logic                 done_flag,
  output logic                 err_flag,
  output logic [JOB_CNT_W-1:0] job_cnt
);

  hpu_state_e state_q, state_d;

  logic [ITEM_W-1:0]    item_num_q, item_num_d;
  logic [ITEM_W-1:0]    mat_a_q, mat_a_d;
  logic                 last_q, last_d;
  logic                 done_flag_q, done_flag_d;
  logic                 err_flag_q, err_flag_d;
  logic [JOB_CNT_W-1:0] job_cnt_q, job_cnt_d;
  logic                 matw_q, run_q, busy_q, done_q;

  logic wdt_en, wdt_clr, wdt_expired;

  assign wdt_en  = (state_q == StLoad) || (state_q == StRun);
  assign wdt_clr = (state_q == StLoad) ? src_beat : (src_beat || dst_last_beat);

  hpu_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .en      (wdt_en),
    .clr     (wdt_clr),
    .expired (wdt_expired)
  );

  always_comb begin
    state_d     = state_q;
    item_num_d  = item_num_q;
    mat_a_d     = mat_a_q;
    last_d      = last_q;
    done_flag_d = done_flag_q;
    err_flag_d  = err_flag_q;
    job_cnt_d   = job_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          item_num_d  = cfg_item_num;
          last_d      = cfg_last;
          mat_a_d     = '0;
          done_flag_d = 1'b0;
          err_flag_d  = 1'b0;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        if (abort || wdt_expired) begin
          err_flag_d = 1'b1;
          state_d    = StIdle;
        end else if (src_beat) begin
          mat_a_d = mat_a_q + 1'b1;
          if (mat_a_q == item_num_q) begin
            state_d = StArm;
          end
        end
      end
      StArm: begin
        if (abort) begin
          err_flag_d = 1'b1;
          state_d    = StIdle;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort || wdt_expired) begin
          err_flag_d = 1'b1;
          state_d    = StIdle;
        end else if (dst_last_beat) begin
          done_flag_d = 1'b1;
          job_cnt_d   = job_cnt_q + 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (abort) begin
          err_flag_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q     <= StIdle;
      item_num_q  <= '0;
      mat_a_q     <= '0;
      last_q      <= 1'b0;
      done_flag_q <= 1'b0;
      err_flag_q  <= 1'b0;
      job_cnt_q   <= '0;
      matw_q      <= 1'b0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      item_num_q  <= item_num_d;
      mat_a_q     <= mat_a_d;
      last_q      <= last_d;
      done_flag_q <= done_flag_d;
      err_flag_q  <= err_flag_d;
      job_cnt_q   <= job_cnt_d;
      // Phase strobes are decoded from the next state so they line up with it.
      matw_q      <= (state_d == StLoad);
      run_q       <= (state_d == StRun);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
    end
  end

  assign matw      = matw_q;
  assign run       = run_q;
  assign last      = last_q;
  assign mat_a     = mat_a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_flag = done_flag_q;
  assign err_flag  = err_flag_q;
  assign job_cnt   = job_cnt_q;

endmodule

// File: tb/tb_hpu_job_seq.sv
// Directed bench for hpu_job_seq (ITEM_W=4, TIMEOUT=16).
module tb_hpu_job_seq;

  localparam int unsigned IW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [IW-1:0] cfg_item_num;
  logic          cfg_last;
  logic          src_beat;
  logic          dst_last_beat;
  logic          matw;
  logic          run;
  logic          last;
  logic [IW-1:0] mat_a;
  logic          busy;
  logic          done;
  logic          done_flag;
  logic          err_flag;
  logic [31:0]   job_cnt;

  int total = 0;
  int bad   = 0;

  hpu_job_seq #(
    .ITEM_W  (IW),
    .TIMEOUT (16)
  ) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .start         (start),
    .abort         (abort),
    .cfg_item_num  (cfg_item_num),
    .cfg_last      (cfg_last),
    .src_beat      (src_beat),
    .dst_last_beat (dst_last_beat),
    .matw          (matw),
    .run           (run),
    .last          (last),
    .mat_a         (mat_a),
    .busy          (busy),
    .done          (done),
    .done_flag     (done_flag),
    .err_flag      (err_flag),
    .job_cnt       (job_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; cfg_item_num = '0; cfg_last = 1'b0;
    src_beat = 1'b0; dst_last_beat = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_matw", 32'(matw), 0);
    chk("rst_run", 32'(run), 0);
    chk("rst_flags", {30'd0, done_flag, err_flag}, 0);
    chk("rst_jobcnt", job_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Job 1: item_num=3, four beats back to back.
    cfg_item_num = 4'd3; cfg_last = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("j1_busy", 32'(busy), 1);
    chk("j1_matw", 32'(matw), 1);
    chk("j1_mata0", 32'(mat_a), 0);
    chk("j1_last", 32'(last), 1);
    for (int i = 0; i < 4; i++) begin
      src_beat = 1'b1;
      tick();
      chk("j1_mata", 32'(mat_a), 32'(i + 1));
      chk("j1_matw_beat", 32'(matw), (i < 3) ? 1 : 0);
    end
    src_beat = 1'b0;
    chk("j1_arm_run", 32'(run), 0);
    chk("j1_arm_busy", 32'(busy), 1);
    tick();
    chk("j1_run", 32'(run), 1);
    tick();
    chk("j1_run_hold", 32'(run), 1);
    dst_last_beat = 1'b1;
    tick();
    dst_last_beat = 1'b0;
    chk("j1_done", 32'(done), 1);
    chk("j1_run_off", 32'(run), 0);
    chk("j1_done_busy", 32'(busy), 1);
    chk("j1_done_flag", 32'(done_flag), 1);
    chk("j1_jobcnt", job_cnt, 1);
    tick();
    chk("j1_done_pulse", 32'(done), 0);
    chk("j1_idle", 32'(busy), 0);
    chk("j1_flag_sticky", 32'(done_flag), 1);

    // Job 2: item_num=7, one beat every 5 cycles, gaps in RUN too.
    cfg_item_num = 4'd7; cfg_last = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("j2_flag_clr", 32'(done_flag), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) tick();
      src_beat = 1'b1;
      tick();
      src_beat = 1'b0;
    end
    chk("j2_mata", 32'(mat_a), 8);
    chk("j2_arm", 32'(matw), 0);
    chk("j2_err", 32'(err_flag), 0);
    tick();
    chk("j2_run", 32'(run), 1);
    repeat (5) tick();
    dst_last_beat = 1'b1;
    tick();
    dst_last_beat = 1'b0;
    chk("j2_done", 32'(done), 1);
    chk("j2_err_end", 32'(err_flag), 0);
    chk("j2_jobcnt", job_cnt, 2);
    tick();

    // Job 3: stall in RUN until the watchdog fires after 16 idle cycles.
    cfg_item_num = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    src_beat = 1'b1;
    tick();
    src_beat = 1'b0;
    tick();
    chk("j3_run", 32'(run), 1);
    repeat (15) tick();
    chk("j3_pre_to_busy", 32'(busy), 1);
    chk("j3_pre_to_err", 32'(err_flag), 0);
    tick();
    chk("j3_to_busy", 32'(busy), 0);
    chk("j3_to_err", 32'(err_flag), 1);
    chk("j3_to_done", 32'(done), 0);
    chk("j3_jobcnt", job_cnt, 2);
    tick();

    // Job 4: start and cfg change mid-job are ignored.
    cfg_item_num = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("j4_err_clr", 32'(err_flag), 0);
    src_beat = 1'b1;
    tick();
    start = 1'b1; cfg_item_num = 4'd0;
    tick();
    start = 1'b0;
    chk("j4_mata2", 32'(mat_a), 2);
    chk("j4_still_load", 32'(matw), 1);
    tick();
    src_beat = 1'b0;
    chk("j4_mata3", 32'(mat_a), 3);
    chk("j4_arm", 32'(matw), 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("j4_run_ign", 32'(run), 1);
    chk("j4_mata_hold", 32'(mat_a), 3);
    dst_last_beat = 1'b1;
    tick();
    dst_last_beat = 1'b0;
    chk("j4_jobcnt", job_cnt, 3);
    tick();

    // Abort in LOAD, then start with abort in IDLE, then clean start.
    cfg_item_num = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    src_beat = 1'b1;
    tick();
    src_beat = 1'b0;
    abort = 1'b1;
    tick();
    chk("ab_busy", 32'(busy), 0);
    chk("ab_err", 32'(err_flag), 1);
    chk("ab_matw", 32'(matw), 0);
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("ab_start_rej", 32'(busy), 0);
    chk("ab_err_hold", 32'(err_flag), 1);
    cfg_item_num = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ab_clean_busy", 32'(busy), 1);
    chk("ab_clean_err", 32'(err_flag), 0);
    src_beat = 1'b1;
    tick();
    src_beat = 1'b0;
    tick();
    dst_last_beat = 1'b1;
    tick();
    dst_last_beat = 1'b0;
    chk("ab_jobcnt", job_cnt, 4);
    tick();

    // Wrap: item_num = 2^IW-1 loads 16 beats and mat_a wraps to 0.
    cfg_item_num = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    src_beat = 1'b1;
    repeat (15) tick();
    chk("wr_mata15", 32'(mat_a), 15);
    chk("wr_matw", 32'(matw), 1);
    tick();
    src_beat = 1'b0;
    chk("wr_mata0", 32'(mat_a), 0);
    chk("wr_arm", 32'(matw), 0);
    tick();
    chk("wr_run", 32'(run), 1);

    // Reset mid-RUN: outputs drop without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("ar_run", 32'(run), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_last", 32'(last), 0);
    chk("ar_jobcnt", job_cnt, 0);
    #2 rst_n = 1'b1;
    tick();
    cfg_item_num = 4'd0; cfg_last = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    src_beat = 1'b1;
    tick();
    src_beat = 1'b0;
    tick();
    dst_last_beat = 1'b1;
    tick();
    dst_last_beat = 1'b0;
    chk("ar_job_done", 32'(done), 1);
    chk("ar_job_cnt", job_cnt, 1);
    chk("ar_job_err", 32'(err_flag), 0);
    tick();
    chk("ar_job_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
